// File: rtl/dff_pkg.sv
// Purpose : shared defaults and helpers for the elastic register pipeline.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// The stage record {v, d} depends on the WIDTH of the module that uses it.
// A package cannot take parameters, so each user declares its own stage_t
// with this field order: valid bit in the MSB, data below it.
package dff_pkg;

  // Default geometry of the pipeline.
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Occupancy counter width. The counter must hold 0..depth inclusive.
  // depth < 1 is illegal, so it is clamped to a 1-bit counter instead of
  // producing a zero-width vector.
  function automatic int dff_cw(input int depth);
    if (depth < 1) begin
      return 1;
    end
    return $clog2(depth + 1);
  endfunction

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// Purpose : one valid+data register stage of the elastic pipeline.
// Latency : 1 cycle from load-enable to registered output.
// Backpressure : none locally; adv (from the top-level chain) gates the load.
//
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   flush          - clears the valid bit (data holds)
//   adv            - stage may load from its upstream neighbour this edge
//   in_v / in_d    - upstream valid and data
//   out_v / out_d  - registered valid and data of this stage
module dff_stage
  import dff_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_v,
  output logic [WIDTH-1:0] out_d
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } stage_t;

  stage_t stg_d;
  stage_t stg_q;

  // Flush clears the valid bit and blocks loading. The data register is
  // written only when a valid word arrives, so a bubble passing through
  // never disturbs the data lines.
  always_comb begin
    stg_d = stg_q;
    if (flush) begin
      stg_d.v = 1'b0;
    end else if (adv) begin
      stg_d.v = in_v;
      if (in_v) begin
        stg_d.d = in_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign out_v = stg_q.v;
  assign out_d = stg_q.d;

endmodule : dff_stage

// File: rtl/dff_pipe_rv.sv
// Purpose : elastic WIDTH x DEPTH register pipeline with valid/ready and flush.
// Latency : DEPTH-1 edges after the accepting edge when empty and unstalled.
// Backpressure : in_ready follows out_ready through the advance chain; bubbles collapse.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   flush                 - synchronous clear of all in-flight data
//   in_data/in_valid/in_ready    - producer side handshake
//   out_data/out_valid/out_ready - consumer side handshake (last stage)
//   count                 - registered number of valid stages, 0..DEPTH
module dff_pipe_rv
  import dff_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CW    = dff_cw(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             accept;
  logic             drain;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  // A stage advances when it is empty or the stage ahead advances.
  // Walking from the output back to the input with a running term avoids
  // a self-referencing vector. The net effect is that stage 0 can load
  // whenever any stage holds a bubble or the consumer is draining.
  always_comb begin
    logic chain;
    chain = out_ready;
    adv   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !v[i] | chain;
      adv[i] = chain;
    end
  end

  assign in_ready = adv[0] & !flush;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (g == 0) begin : g_head
      assign up_v = accept;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[g-1];
      assign up_d = d[g-1];
    end

    dff_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .adv   (adv[g]),
      .in_v  (up_v),
      .in_d  (up_d),
      .out_v (v[g]),
      .out_d (d[g])
    );
  end

  // Occupancy tracks popcount(v) incrementally. A drain in the flush cycle
  // still completes toward the consumer, but the flush zeroes the count anyway.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({accept, drain})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = count_q;

endmodule : dff_pipe_rv
